cgra_stim_checker: RTL
======================

// Module: cgra_stim_checker
// PURPOSE
//  Synthesizable CGRA self-test harness. Streams (addr,data) config beats into the fabric config port,
//  then drives per-lane counting stimulus onto the pad inputs. It checks the fabric pad outputs
//  against SCALE*stimulus after a fixed pipeline latency, and reports pass/fail, mismatch count and cycle count.
//  Sits beside `top`; generalises the single-lane x2 check to N lanes, any scale, latency and run length.
// PARAMETERS
//  DATA_W      16     lane width (bits)
//  LANES       1      number of independent stimulus/check lanes (1..8)
//  START       3      stimulus value of lane 0 on first RUN cycle
//  STEP        1      per-cycle stimulus increment
//  SCALE       2      expected gain: expected = SCALE*stim mod 2^DATA_W
//  LATENCY     2      fabric pipeline latency in cycles (0..31)
//  SETTLE      4      extra RUN cycles ignored before checking starts
//  RUN_CYCLES  10000  RUN length in cycles
//  ERR_W       16     mismatch counter width (saturating)
//  CYC_W       32     cycle counter width
// PORTS
//  clk_in           in   1               clock
//  reset_in         in   1               reset, synchronous active-high
//  start            in   1               start pulse; honoured only in IDLE or DONE
//  cfg_in_valid     in   1               config beat valid
//  cfg_in_ready     out  1               config beat ready (1 only in CONFIG)
//  cfg_in_addr      in   32              config address
//  cfg_in_data      in   32              config data
//  cfg_in_last      in   1               marks final config beat
//  config_addr_out  out  32              to fabric config_addr_in; 0 = no-op
//  config_data_out  out  32              to fabric config_data_in
//  stim_out         out  LANES*DATA_W    pad stimulus; lane i at [i*DATA_W +: DATA_W]
//  dut_in           in   LANES*DATA_W    fabric pad outputs, same packing
//  busy             out  1               1 in CONFIG/RUN
//  done             out  1               1 in DONE
//  pass             out  1               done && err_count==0
//  err_count        out  ERR_W           lane-mismatch count, saturates at all-ones
//  cycle_count      out  CYC_W           RUN cycles elapsed
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, including cfg_in_ready, config_*_out, stim_out and counters.
//    Reset in any state aborts immediately; no partial config is replayed.
//  - FSM: IDLE -start-> CONFIG; CONFIG -accepted beat with last-> RUN; RUN -cycle_count==RUN_CYCLES-1-> DONE.
//    DONE -start-> CONFIG, clearing err_count, cycle_count and stim. start in CONFIG or RUN is ignored.
//  - CONFIG: cfg_in_ready=1. A beat accepted (valid&ready) at cycle t appears on config_addr_out and
//    config_data_out at t+1 for exactly one cycle; otherwise both are 0. No beat limit; the stall is unbounded.
//  - RUN cycle k (k=0 is the first): stim lane i = START + k*STEP + i, mod 2^DATA_W, registered.
//    The stim value wraps silently. Outside RUN, stim_out holds 0.
//  - Check at RUN cycle k applies when k >= LATENCY+SETTLE. For each lane, dut lane !=
//    (SCALE*stim lane at k-LATENCY) mod 2^DATA_W counts as one error.
//    Multiple failing lanes in one cycle add their count; the sum is clamped at 2^ERR_W-1.
//  - cycle_count increments every RUN cycle and freezes in DONE. pass and done are registered and valid
//    from the first DONE cycle. Products use 2*DATA_W bits and are truncated to DATA_W.
// CONFIGURATION
//  FIRST_FAIL_CAPTURE_EN defined: adds outputs ff_valid(1), ff_cycle(CYC_W), ff_lane(3),
//  ff_expected(DATA_W), ff_actual(DATA_W). These latch the first mismatch (lowest lane on a tie) and
//  hold until reset or restart; all are 0 at reset.
//  Macro undefined: those ports and registers do not exist; the other behaviour is identical.
// STRUCTURE
//  Package cgra_stim_pkg: state enum {IDLE,CONFIG,RUN,DONE}; CFG_ADDR_W=32, CFG_DATA_W=32, CFG_NOP_ADDR=0.
//  Sub-module stim_delay_line: shift register of width LANES*DATA_W and depth LATENCY, reset to 0.
//  When LATENCY=0 it is a combinational pass-through. It supplies the delayed stimulus used to form the expected value.
// TESTING
//  1. Defaults, 3 config beats, DUT model = 2x with 2-cycle delay -> 3 one-cycle config pulses, then 0.
//     Expect done after 10000 RUN cycles, pass=1, err_count=0.
//  2. Hold cfg_in_valid low 5 cycles mid-CONFIG -> config_addr_out stays 0 and RUN does not start until last.
//  3. DUT forces lane 0 to 0 for 3 cycles at k=100 -> err_count=3, pass=0.
//     With FIRST_FAIL_CAPTURE_EN: ff_cycle=100, ff_lane=0, ff_expected=2*(3+98)=202, ff_actual=0.
//  4. LANES=4, START=16'hFFFE -> lane 1 wraps to 16'hFFFF, lane 2 to 0; with a correct DUT, err_count=0.
//  5. Assert reset_in during RUN at k=50 -> next cycle state IDLE and all outputs 0.
//     A following start restarts config from the first beat.
//  6. Error storm with ERR_W=4, LANES=2, both lanes wrong every cycle -> err_count saturates at 15.

Source files
------------

// File: rtl/cgra_stim_pkg.sv
// Shared types and constants for the CGRA stimulus/checker harness.
//   state_e       : harness FSM states
//   CFG_ADDR_W    : config-port address width
//   CFG_DATA_W    : config-port data width
//   CFG_NOP_ADDR  : address value the fabric treats as "no config write"
//   popcount8     : counts set bits in an 8-bit lane-error vector
package cgra_stim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned CFG_ADDR_W = 32;
    localparam int unsigned CFG_DATA_W = 32;
    localparam logic [CFG_ADDR_W-1:0] CFG_NOP_ADDR = '0;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/stim_delay_line.sv
// Fixed-latency delay line for the packed stimulus bus.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears every stage to 0
//   data_i : WIDTH-bit input word
//   data_o : data_i delayed by DEPTH cycles (combinational when DEPTH == 0)
module stim_delay_line #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_bypass
        assign data_o = data_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [DEPTH];
        logic [WIDTH-1:0] pipe_d [DEPTH];

        always_comb begin
            pipe_d[0] = data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign data_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/cgra_stim_checker.sv
// CGRA self-test harness: streams config beats into the fabric, then drives per-lane counting
// stimulus onto the pads and checks the pad outputs against SCALE*stimulus after LATENCY cycles.
//   clk_in / reset_in            : clock, synchronous active-high reset
//   start                        : run request, honoured in IDLE or DONE
//   cfg_in_*                     : config beat stream (valid/ready/addr/data/last)
//   config_addr_out/data_out     : one-cycle config write to the fabric (addr 0 = no-op)
//   stim_out / dut_in            : packed pad stimulus / fabric pad outputs, lane i at [i*DATA_W +: DATA_W]
//   busy, done, pass             : status (pass = done with zero errors)
//   err_count, cycle_count       : saturating lane-error count, RUN cycles elapsed
// Optional: define FIRST_FAIL_CAPTURE_EN to add ff_valid/ff_cycle/ff_lane/ff_expected/ff_actual,
// which latch the first failing lane (lowest lane on a tie) until reset or restart.
module cgra_stim_checker
    import cgra_stim_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LANES      = 1,
    parameter int unsigned START      = 3,
    parameter int unsigned STEP       = 1,
    parameter int unsigned SCALE      = 2,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned RUN_CYCLES = 10000,
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned CYC_W      = 32
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start,
    input  logic                    cfg_in_valid,
    output logic                    cfg_in_ready,
    input  logic [CFG_ADDR_W-1:0]   cfg_in_addr,
    input  logic [CFG_DATA_W-1:0]   cfg_in_data,
    input  logic                    cfg_in_last,
    output logic [CFG_ADDR_W-1:0]   config_addr_out,
    output logic [CFG_DATA_W-1:0]   config_data_out,
    output logic [LANES*DATA_W-1:0] stim_out,
    input  logic [LANES*DATA_W-1:0] dut_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
`ifdef FIRST_FAIL_CAPTURE_EN
    output logic                    ff_valid,
    output logic [CYC_W-1:0]        ff_cycle,
    output logic [2:0]              ff_lane,
    output logic [DATA_W-1:0]       ff_expected,
    output logic [DATA_W-1:0]       ff_actual,
`endif
    output logic [CYC_W-1:0]        cycle_count
);

    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(RUN_CYCLES - 1);
    localparam logic [CYC_W-1:0] CHK_START = CYC_W'(LATENCY + SETTLE);

    state_e                  state_q, state_d;
    logic [CFG_ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
    logic [CFG_DATA_W-1:0]   cfg_data_q, cfg_data_d;
    logic [LANES*DATA_W-1:0] stim_q, stim_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;

    logic [LANES*DATA_W-1:0] stim_init, stim_next, stim_dly;
    logic [DATA_W-1:0]       exp_lane [LANES];
    logic [LANES-1:0]        mismatch;
    logic                    check_en;
    logic [ERR_W+3:0]        err_sum;
    logic [ERR_W-1:0]        err_sat;

    // Expected values are formed from the stimulus as it was LATENCY cycles ago.
    stim_delay_line #(
        .WIDTH (LANES * DATA_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk_i  (clk_in),
        .rst_i  (reset_in),
        .data_i (stim_q),
        .data_o (stim_dly)
    );

    assign check_en = (state_q == RUN) && (cyc_q >= CHK_START);

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        assign stim_init[i*DATA_W +: DATA_W] = DATA_W'(START + i);
        assign stim_next[i*DATA_W +: DATA_W] = stim_q[i*DATA_W +: DATA_W] + DATA_W'(STEP);
        // Full-width product, truncated to the lane width.
        assign exp_lane[i] = DATA_W'((2*DATA_W)'(SCALE) * (2*DATA_W)'(stim_dly[i*DATA_W +: DATA_W]));
        assign mismatch[i] = check_en && (dut_in[i*DATA_W +: DATA_W] != exp_lane[i]);
    end

    // Extra headroom bits so a whole cycle of lane errors can be added before clamping.
    assign err_sum = (ERR_W+4)'(err_q) + (ERR_W+4)'(popcount8(8'(mismatch)));
    assign err_sat = (err_sum > (ERR_W+4)'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

    always_comb begin
        state_d    = state_q;
        cfg_addr_d = CFG_NOP_ADDR;
        cfg_data_d = '0;
        stim_d     = stim_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        done_d     = done_q;
        pass_d     = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONFIG;
                end
            end
            CONFIG: begin
                if (cfg_in_valid) begin
                    cfg_addr_d = cfg_in_addr;
                    cfg_data_d = cfg_in_data;
                    if (cfg_in_last) begin
                        state_d = RUN;
                        stim_d  = stim_init;
                    end
                end
            end
            RUN: begin
                cyc_d  = cyc_q + 1'b1;
                err_d  = err_sat;
                stim_d = stim_next;
                if (cyc_q == LAST_CYC) begin
                    state_d = DONE;
                    stim_d  = '0;
                    done_d  = 1'b1;
                    pass_d  = (err_sat == '0);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = CONFIG;
                    err_d   = '0;
                    cyc_d   = '0;
                    stim_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            cfg_addr_q <= CFG_NOP_ADDR;
            cfg_data_q <= '0;
            stim_q     <= '0;
            err_q      <= '0;
            cyc_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            stim_q     <= stim_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign cfg_in_ready    = (state_q == CONFIG);
    assign busy            = (state_q == CONFIG) || (state_q == RUN);
    assign done            = done_q;
    assign pass            = pass_q;
    assign config_addr_out = cfg_addr_q;
    assign config_data_out = cfg_data_q;
    assign stim_out        = stim_q;
    assign err_count       = err_q;
    assign cycle_count     = cyc_q;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic              ff_valid_q, ff_valid_d;
    logic [CYC_W-1:0]  ff_cycle_q, ff_cycle_d;
    logic [2:0]        ff_lane_q, ff_lane_d;
    logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
    logic [DATA_W-1:0] ff_act_q, ff_act_d;

    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_cycle_d = ff_cycle_q;
        ff_lane_d  = ff_lane_q;
        ff_exp_d   = ff_exp_q;
        ff_act_d   = ff_act_q;
        if (state_q == DONE && start) begin
            ff_valid_d = 1'b0;
            ff_cycle_d = '0;
            ff_lane_d  = '0;
            ff_exp_d   = '0;
            ff_act_d   = '0;
        end else if (!ff_valid_q && (|mismatch)) begin
            ff_valid_d = 1'b1;
            ff_cycle_d = cyc_q;
            // Scan downward so the lowest failing lane wins.
            for (int i = int'(LANES) - 1; i >= 0; i--) begin
                if (mismatch[i]) begin
                    ff_lane_d = 3'(i);
                    ff_exp_d  = exp_lane[i];
                    ff_act_d  = dut_in[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ff_valid_q <= 1'b0;
            ff_cycle_q <= '0;
            ff_lane_q  <= '0;
            ff_exp_q   <= '0;
            ff_act_q   <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_cycle_q <= ff_cycle_d;
            ff_lane_q  <= ff_lane_d;
            ff_exp_q   <= ff_exp_d;
            ff_act_q   <= ff_act_d;
        end
    end

    assign ff_valid    = ff_valid_q;
    assign ff_cycle    = ff_cycle_q;
    assign ff_lane     = ff_lane_q;
    assign ff_expected = ff_exp_q;
    assign ff_actual   = ff_act_q;
`endif

endmodule
